// File: rtl/mealy_seq_pkg.sv
// Shared definitions for the Mealy sequence detector: state encoding,
// default pattern/counter constants and a small sizing helper.
package mealy_seq_pkg;

  // FILL: history not yet full; ARMED: history holds PAT_W-1 valid bits
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int                     DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN = 4'b1011;
  localparam int                     DEF_CNT_W   = 8;

  // Width of the fill counter, which must hold values 0..pat_w-1
  function automatic int fill_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// sat_counter: up-counter that stops at its all-ones value instead of
// wrapping. Synchronous active-high reset.
module sat_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;

  // Count up on inc, hold once every bit is set
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {width{1'b1}})) begin
      count_q <= count_q + width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: serial pattern detector with a Mealy match flag.
// A history shift register holds the newest PAT_W-1 accepted bits; once it
// is full (state ARMED) the incoming bit completes the comparison in the
// same cycle, so y is combinational from state, x, x_valid and rst.
//
// Build option: define MEALY_SEQ_DETECTOR_CNT_EN to implement the saturating
// match counter; without it match_cnt is tied to zero and no counter exists.
//
// Input handshake: x_valid/x is a valid-only stream with no back-pressure.
// A bit is accepted on any rising edge where x_valid=1 and rst=0; when
// x_valid=0 the value on x is ignored and all state holds.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               HIST_W   = PAT_W - 1;
  localparam int               FILL_W   = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  // state_q is the FSM state register; it is kept as a named signal so
  // checkers can bind to it directly.
  state_t              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [FILL_W-1:0]   fill_inc;
  logic                match;
  logic                y_q_r;

  assign fill_inc = fill_q + FILL_W'(1);

  // Match decode and next-state: shift history on every accepted bit,
  // grow fill until armed, and on a match either stay armed (overlap) or
  // restart the fill so matched bits cannot be reused.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match   = !rst && x_valid && (state_q == ARMED) && ({hist_q, x} == PATTERN);

    if (x_valid) begin
      hist_d = HIST_W'({hist_q, x});
      if (match) begin
        if (OVERLAP != 0) begin
          fill_d  = FILL_MAX;
          state_d = ARMED;
        end else begin
          fill_d  = '0;
          state_d = FILL;
        end
      end else if (fill_q != FILL_MAX) begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_MAX) ? ARMED : FILL;
      end
    end
  end

  // State, history, fill and registered match flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q_r   <= match;
    end
  end

  assign y   = match;
  assign y_q = y_q_r;

`ifdef MEALY_SEQ_DETECTOR_CNT_EN
  sat_counter #(
    .width(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .count(match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: doc/mealy_seq_detector.md
MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
- REQ-001: Parameter PAT_W, default 4, pattern length in bits; legal range 2..16.
- REQ-002: Parameter PATTERN, default 4'b1011, PAT_W-bit target; PATTERN[PAT_W-1] is the first bit received.
- REQ-003: Parameter OVERLAP, default 1; 1 lets the tail of a match seed the next match, 0 restarts after a match.
- REQ-004: Parameter CNT_W, default 8, width of match_cnt; legal range 1..32.
- REQ-005: Port clk, input, 1, single rising-edge clock; all state SHALL change only on this edge.
- REQ-006: Port rst, input, 1, synchronous active-high reset.
- REQ-007: Port x_valid, input, 1, qualifies x; when 0, the bit is ignored.
- REQ-008: Port x, input, 1, serial data bit.
- REQ-009: Port y, output, 1, Mealy match flag, combinational from state, x, x_valid and rst.
- REQ-010: Port y_q, output, 1, y registered one cycle later.
- REQ-011: Port match_cnt, output, CNT_W, saturating count of matches.

Function
- REQ-012: The block SHALL hold hist, a (PAT_W-1)-bit shift register of the newest accepted bits, and fill, a count 0..PAT_W-1 of valid bits in hist.
- REQ-013: Two states SHALL exist: FILL (fill < PAT_W-1) and ARMED (fill = PAT_W-1).
- REQ-014: y SHALL be 1 iff rst=0, x_valid=1, state=ARMED and {hist, x} = PATTERN; otherwise y = 0.
- REQ-015: On an accepted bit (x_valid=1), hist SHALL shift left, with x entering the LSB.
- REQ-016: On an accepted bit with y=0, fill SHALL increment, saturating at PAT_W-1, so that FILL moves to ARMED after exactly PAT_W-1 accepted bits.
- REQ-017: On an accepted bit with y=1 and OVERLAP=1, fill SHALL stay at PAT_W-1 and the state SHALL stay ARMED.
- REQ-018: On an accepted bit with y=1 and OVERLAP=0, fill SHALL go to 0 and the state to FILL; the matched bits SHALL NOT contribute to a later match.
- REQ-019: With x_valid=0, hist, fill, state and match_cnt SHALL hold, and y SHALL be 0; gaps of any length are transparent.
- REQ-020: y_q SHALL equal the previous cycle's y (latency 1).
- REQ-021: match_cnt SHALL increment by 1 on each cycle with y=1, and SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
- REQ-022: With rst=1 at a clk edge, the block SHALL set hist=0, fill=0, state=FILL, y_q=0 and match_cnt=0.
- REQ-023: rst SHALL override x_valid in the same cycle; the bit presented during that cycle is discarded.
- REQ-024: A reset asserted mid-pattern SHALL discard the partial match; at least PAT_W accepted bits SHALL follow before y can assert again.

Configuration
- REQ-025: Macro MEALY_SEQ_DETECTOR_CNT_EN defined: match_cnt is implemented per REQ-021.
- REQ-026: MEALY_SEQ_DETECTOR_CNT_EN undefined: no counter register exists, and match_cnt SHALL be tied to 0 with the port still present.

Structure
- REQ-027: A shared package mealy_seq_pkg SHALL hold the state encoding typedef (FILL, ARMED) and the default constants for PAT_W, PATTERN and CNT_W.
- REQ-028: The saturating counter SHALL be a separate sub-module sat_counter, with parameter width and inputs clk, rst and inc, instantiated only under MEALY_SEQ_DETECTOR_CNT_EN.

Verification
- REQ-029: Overlap case. Default parameters; after reset, bits 1,0,1,1,0,1,1 with x_valid=1 -> y=1 on bits 4 and 7 only; y_q=1 on the following cycles; match_cnt=2.
- REQ-030: Non-overlap case. OVERLAP=0, same stream -> y=1 on bit 4 only; match_cnt=1.
- REQ-031: Reset mid-pattern. Bits 1,0,1, then one cycle with rst=1 and x_valid=1 and x=1, then 1 -> y stays 0 throughout; bits 0,1,1 then follow -> y=1 on the final 1.
- REQ-032: Valid gaps. Bits 1,0, then 3 cycles with x_valid=0 and x toggling, then 1,1 -> y=1 only on the last bit; y=0 during the gap.
- REQ-033: Saturation. Counter macro defined, CNT_W=2, 5 overlapping matches of 1011 -> match_cnt reads 1,2,3,3,3.
- REQ-034: Macro off. Stream from REQ-029 -> match_cnt=0 throughout; y and y_q are identical to REQ-029.
